ms_timebase: RTL

Fractional-rate timebase that produces the one_ms strobe consumed by the delay timers in the sim/peripheral models. Uses a phase accumulator, so the long-run tick rate is exact for any clock frequency, including non-integer ratios. Also provides a one-second strobe and a free-running millisecond count for model bookkeeping. One instance per clock domain; its one_ms output fans out to every delay instance.

---
 rtl/timebase_pkg.sv | 12 +
 rtl/ms_timebase_frac_divider.sv | 51 +++++
 rtl/ms_timebase.sv | 75 +++++++
 3 files changed

// File: rtl/timebase_pkg.sv
// Shared constants and sizing helper for the fractional-rate millisecond timebase.
package timebase_pkg;

  localparam int DEF_CLK_HZ  = 32'd100_000_000;
  localparam int DEF_TICK_HZ = 32'd1000;

  // Accumulator must hold acc + TICK_HZ, whose maximum is CLK_HZ + TICK_HZ - 1.
  function automatic int acc_width(input int clk_hz, input int tick_hz);
    return $clog2(clk_hz + tick_hz);
  endfunction

endpackage

// File: rtl/ms_timebase_frac_divider.sv
// Phase-accumulator divider: adds TICK_HZ per enabled cycle and fires tick when
// the phase crosses CLK_HZ, keeping the remainder so the long-run rate is exact.
module frac_divider
  import timebase_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int TICK_HZ = DEF_TICK_HZ,
  parameter int ACC_W   = acc_width(CLK_HZ, TICK_HZ)
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic resync,
  output logic tick
);

  localparam logic [ACC_W-1:0] C_CLK  = ACC_W'(CLK_HZ);
  localparam logic [ACC_W-1:0] C_TICK = ACC_W'(TICK_HZ);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_next;
  logic             w_wrap;

  // Next phase: wrap by subtracting CLK_HZ once the sum reaches it.
  always_comb begin
    w_sum  = r_acc + C_TICK;
    w_wrap = (w_sum >= C_CLK);
    if (w_wrap) begin
      w_next = w_sum - C_CLK;
    end else begin
      w_next = w_sum;
    end
  end

  // Phase register; resync restarts the phase, enable low freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= {ACC_W{1'b0}};
    end else if (resync) begin
      r_acc <= {ACC_W{1'b0}};
    end else if (enable) begin
      r_acc <= w_next;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign tick = enable & ~resync & w_wrap;

endmodule

// File: rtl/ms_timebase.sv
// Millisecond timebase: registered one_ms / one_s strobes plus a free-running
// tick count, driven by the fractional divider.
module ms_timebase
  import timebase_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int TICK_HZ = DEF_TICK_HZ,
  parameter int CNT_W   = 32'd32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             resync,
  output logic             one_ms,
  output logic             one_s,
  output logic [CNT_W-1:0] ms_count
);

  localparam int              SUB_W      = (TICK_HZ > 32'd1) ? $clog2(TICK_HZ) : 32'd1;
  localparam logic [SUB_W-1:0] C_SUB_LAST = SUB_W'(TICK_HZ - 32'd1);

  if ((TICK_HZ <= 32'd0) || (TICK_HZ > CLK_HZ)) begin : g_bad_ratio
    $fatal(1, "ms_timebase: TICK_HZ must be in 1..CLK_HZ");
  end

  logic             w_tick;
  logic             w_sub_last;
  logic [SUB_W-1:0] r_sub;
  logic             r_one_ms;
  logic             r_one_s;
  logic [CNT_W-1:0] r_ms_count;

  frac_divider #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .resync (resync),
    .tick   (w_tick)
  );

  assign w_sub_last = (r_sub == C_SUB_LAST);

  // Strobes, sub-second position and tick count; w_tick is already masked by enable/resync.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sub      <= {SUB_W{1'b0}};
      r_one_ms   <= 1'b0;
      r_one_s    <= 1'b0;
      r_ms_count <= {CNT_W{1'b0}};
    end else begin
      r_one_ms <= w_tick;
      r_one_s  <= w_tick & w_sub_last;
      if (resync) begin
        r_sub <= {SUB_W{1'b0}};
      end else if (w_tick) begin
        r_sub <= w_sub_last ? {SUB_W{1'b0}} : (r_sub + SUB_W'(1));
      end else begin
        r_sub <= r_sub;
      end
      if (w_tick) begin
        r_ms_count <= r_ms_count + CNT_W'(1);
      end else begin
        r_ms_count <= r_ms_count;
      end
    end
  end

  assign one_ms   = r_one_ms;
  assign one_s    = r_one_s;
  assign ms_count = r_ms_count;

endmodule
